window_3x3_gen: RTL and testbench

Streaming 3x3 neighbourhood generator that sits directly upstream of `simple_avg`. It accepts one 4-bit pixel per accepted cycle in raster order and buffers the two previous image rows. It presents the nine pixels of the current 3x3 window on `pixel_1`..`pixel_9`, with a `window_valid` qualifier. Windows are emitted only when fully inside the image; there is no padding.

---
 rtl/img_pkg.sv | 7 +
 rtl/window_3x3_gen_if.sv | 22 ++
 rtl/line_buffer.sv | 21 ++
 rtl/window_3x3_gen.sv | 95 +++++++++
 tb/tb_window_3x3_gen.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/img_pkg.sv
// Pixel types and window constants shared by the image blocks
// (window_3x3_gen, simple_avg, convolution).
package img_pkg;
    parameter int PIX_W = 4;
    typedef logic [PIX_W-1:0] pixel_t;
    localparam int WIN_SIZE = 9;
endpackage

// File: rtl/window_3x3_gen_if.sv
// Pixel stream in, 3x3 window out. The slave side is the window generator.
interface window_3x3_gen_if #(parameter int PIX_W = img_pkg::PIX_W);
    logic [PIX_W-1:0] pixel_in;
    logic             pixel_valid;
    logic             sof;
    logic [PIX_W-1:0] pixel_1, pixel_2, pixel_3;
    logic [PIX_W-1:0] pixel_4, pixel_5, pixel_6;
    logic [PIX_W-1:0] pixel_7, pixel_8, pixel_9;
    logic             window_valid;
    logic             frame_done;

    modport master (
        output pixel_in, pixel_valid, sof,
        input  pixel_1, pixel_2, pixel_3, pixel_4, pixel_5,
               pixel_6, pixel_7, pixel_8, pixel_9, window_valid, frame_done
    );
    modport slave (
        input  pixel_in, pixel_valid, sof,
        output pixel_1, pixel_2, pixel_3, pixel_4, pixel_5,
               pixel_6, pixel_7, pixel_8, pixel_9, window_valid, frame_done
    );
endinterface

// File: rtl/line_buffer.sv
// One image row of storage, single address. The read is combinational, so a
// write to the same address on this edge returns the old row's pixel.
module line_buffer #(
    parameter int DEPTH = 16,
    parameter int W     = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];
endmodule

// File: rtl/window_3x3_gen.sv
// Raster-order 3x3 window generator: two chained line buffers feed a 3x3
// shift register; a window is flagged valid only when fully inside the image.
module window_3x3_gen
    import img_pkg::*;
#(
    parameter int IMG_WIDTH  = 16,
    parameter int IMG_HEIGHT = 16,
    parameter int PIX_W      = img_pkg::PIX_W
) (
    input  logic            clk,
    input  logic            reset,
    window_3x3_gen_if.slave bus
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    logic [CW-1:0] col, cur_col;
    logic [RW-1:0] row, cur_row;
    logic          accept, last_col, last_row;

    // sof forces the incoming pixel to (0,0) whatever the counters say
    assign accept   = bus.pixel_valid;
    assign cur_col  = bus.sof ? '0 : col;
    assign cur_row  = bus.sof ? '0 : row;
    assign last_col = (cur_col == CW'(IMG_WIDTH - 1));
    assign last_row = (cur_row == RW'(IMG_HEIGHT - 1));

    // Tap 0 holds row r-1, tap 1 holds row r-2 (fed from tap 0's read data)
    logic [1:0][PIX_W-1:0] lb_wdata, lb_rdata;
    assign lb_wdata = {lb_rdata[0], bus.pixel_in};

    for (genvar i = 0; i < 2; i++) begin : g_lb
        line_buffer #(.DEPTH(IMG_WIDTH), .W(PIX_W), .AW(CW)) u_lb (
            .clk   (clk),
            .we    (accept),
            .addr  (cur_col),
            .wdata (lb_wdata[i]),
            .rdata (lb_rdata[i])
        );
    end

    logic [PIX_W-1:0] new_col [3];
    assign new_col[0] = lb_rdata[1];
    assign new_col[1] = lb_rdata[0];
    assign new_col[2] = bus.pixel_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : cur_row + 1'b1;
            end else begin
                col <= cur_col + 1'b1;
                row <= cur_row;
            end
        end
    end

    // Window stored row-major: index 0 is top-left, index 8 the newest pixel
    logic [PIX_W-1:0] win [WIN_SIZE];
    logic             win_valid, done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < WIN_SIZE; k++) win[k] <= '0;
            win_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            win_valid <= accept && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
            done      <= accept && last_col && last_row;
            if (accept) begin
                for (int r = 0; r < 3; r++) begin
                    win[3*r]     <= win[3*r + 1];
                    win[3*r + 1] <= win[3*r + 2];
                    win[3*r + 2] <= new_col[r];
                end
            end
        end
    end

    assign bus.pixel_1      = win[0];
    assign bus.pixel_2      = win[1];
    assign bus.pixel_3      = win[2];
    assign bus.pixel_4      = win[3];
    assign bus.pixel_5      = win[4];
    assign bus.pixel_6      = win[5];
    assign bus.pixel_7      = win[6];
    assign bus.pixel_8      = win[7];
    assign bus.pixel_9      = win[8];
    assign bus.window_valid = win_valid;
    assign bus.frame_done   = done;
endmodule

// File: tb/tb_window_3x3_gen.sv
// Randomised and directed bench for window_3x3_gen on a 4x4 image, checked
// against a frame-array reference model.
module tb_window_3x3_gen;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int PW = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    window_3x3_gen_if #(.PIX_W(PW)) bus ();

    window_3x3_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(PW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: the frame as a 2-D array and a linear position
    logic [PW-1:0] img [H][W];
    int            pos     = 0;
    int            win_cnt = 0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [9*PW-1:0] dut_win();
        return {bus.pixel_1, bus.pixel_2, bus.pixel_3, bus.pixel_4, bus.pixel_5,
                bus.pixel_6, bus.pixel_7, bus.pixel_8, bus.pixel_9};
    endfunction

    task automatic model_reset();
        pos     = 0;
        win_cnt = 0;
    endtask

    // One clock: drive, predict, clock, check one ns after the edge
    task automatic step(bit v, logic [PW-1:0] p, bit s);
        bit              ev = 0;
        bit              ed = 0;
        logic [9*PW-1:0] ew = '0;
        int              r, c;
        bus.pixel_valid = v;
        bus.pixel_in    = p;
        bus.sof         = s;
        if (v) begin
            if (s) begin
                pos     = 0;
                win_cnt = 0;
            end
            r = pos / W;
            c = pos % W;
            img[r][c] = p;
            ev = (r >= 2) && (c >= 2);
            if (ev)
                for (int k = 0; k < 9; k++) ew = {ew[8*PW-1:0], img[r-2+k/3][c-2+k%3]};
            ed  = (pos == W*H - 1);
            pos = (pos + 1) % (W*H);
        end
        @(posedge clk);
        #1;
        chk("window_valid", 64'(bus.window_valid), 64'(ev));
        chk("frame_done", 64'(bus.frame_done), 64'(ed));
        if (ev) chk("window", 64'(dut_win()), 64'(ew));
        if (bus.window_valid) win_cnt++;
        if (ed) begin
            chk("wins_per_frame", 64'(win_cnt), 64'((W-2)*(H-2)));
            win_cnt = 0;
        end
    endtask

    task automatic idle();
        step(1'b0, PW'($urandom), 1'($urandom));
    endtask

    // mode 0: value = raster index, mode 1: 15 - index, mode 2: random
    task automatic frame(int mode, bit toggle, bit sof_first);
        logic [PW-1:0] p;
        for (int i = 0; i < W*H; i++) begin
            case (mode)
                0:       p = PW'(i);
                1:       p = PW'(15 - i);
                default: p = PW'($urandom);
            endcase
            step(1'b1, p, sof_first && (i == 0));
            if (toggle) idle();
        end
    endtask

    initial begin
        reset           = 1'b1;
        bus.pixel_valid = 1'b0;
        bus.pixel_in    = '0;
        bus.sof         = 1'b0;
        #12;
        chk("rst_window_valid", 64'(bus.window_valid), 64'd0);
        chk("rst_frame_done", 64'(bus.frame_done), 64'd0);
        chk("rst_window", 64'(dut_win()), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Continuous, toggled, then two back-to-back frames (second inverted)
        frame(0, 1'b0, 1'b1);
        idle();
        frame(0, 1'b1, 1'b1);
        frame(0, 1'b0, 1'b1);
        frame(1, 1'b0, 1'b1);
        idle();

        // Restart after 7 pixels
        for (int i = 0; i < 7; i++) step(1'b1, PW'(i), i == 0);
        frame(2, 1'b0, 1'b1);

        // sof coinciding with the last pixel of a frame
        for (int i = 0; i < W*H - 1; i++) step(1'b1, PW'($urandom), i == 0);
        step(1'b1, PW'($urandom), 1'b1);
        for (int i = 1; i < W*H; i++) step(1'b1, PW'($urandom), 1'b0);

        // Asynchronous reset between edges, mid-frame
        for (int i = 0; i < 11; i++) step(1'b1, PW'(i), i == 0);
        #3 reset = 1'b1;
        #1;
        chk("arst_window_valid", 64'(bus.window_valid), 64'd0);
        chk("arst_frame_done", 64'(bus.frame_done), 64'd0);
        chk("arst_window", 64'(dut_win()), 64'd0);
        #2 reset = 1'b0;
        model_reset();
        frame(0, 1'b0, 1'b0);
        frame(2, 1'b0, 1'b0);

        // Random traffic with occasional sof
        for (int n = 0; n < 800; n++) begin
            bit v;
            v = ($urandom_range(0, 3) != 0);
            step(v, PW'($urandom), v && ($urandom_range(0, 40) == 0));
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
